// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared types and constants for the multi-port register file.
//   - clr_state_e : states of the sequential clear engine
//   - DEF_DATA_W  : default register width
//   - DEF_ADDR_W  : default address width (DEPTH = 2**ADDR_W)
//   - MAX_NUM_RD  : upper bound on the number of read ports
// ---------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_NUM_RD = 4;

endpackage : regfile_pkg

// File: rtl/regfile_clear_fsm.sv
// ---------------------------------------------------------------------------
// regfile_clear_fsm
//   Sequential clear engine for the register file. On a clear request it walks
//   a counter over every entry, one entry per clock, and reports which entry
//   the array must zero on the current edge.
//
// Ports:
//   clock        in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   i_clear_req  in   start a clear (sampled in IDLE only)
//   o_busy       out  high while the clear sweep runs
//   o_clr_en     out  zero entry o_clr_addr at the coming edge
//   o_clr_addr   out  entry being cleared this cycle
// ---------------------------------------------------------------------------
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              i_clear_req,
  output logic              o_busy,
  output logic              o_clr_en,
  output logic [ADDR_W-1:0] o_clr_addr
);

  // Terminal count is the last entry; the counter never wraps past it.
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  clr_state_e        r_state;
  clr_state_e        w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_next;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_clear_req) begin
          w_state_next = ST_CLEAR;
          w_cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Output logic: purely a function of the current state and counter.
  always_comb begin
    o_busy     = (r_state == ST_CLEAR);
    o_clr_en   = (r_state == ST_CLEAR);
    o_clr_addr = r_cnt;
  end

endmodule : regfile_clear_fsm

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-port register file: two write ports (A has priority over B),
//   NUM_RD asynchronous read ports, optional hardwired zero entry, and a
//   sequential clear engine that zeroes the array without a full reset.
//
//   Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
//   to matching read ports (port A over port B). Undefined, reads return
//   array contents only.
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   NUM_RD    number of read ports (1..MAX_NUM_RD)
//   ZERO_REG  1: entry 0 reads 0 and ignores writes
//
// Ports:
//   clock       in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   RegWrite    in   port A write enable
//   Write_Reg   in   port A write address
//   writeData   in   port A write data
//   RegWrite2   in   port B write enable
//   Write_Reg2  in   port B write address
//   writeData2  in   port B write data
//   Read_Reg    in   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   Read_Data   out  packed read data,      port i at [i*DATA_W +: DATA_W]
//   clear_req   in   request a sequential clear of all entries
//   busy        out  high while the clear engine runs
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        Write_Reg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     RegWrite2,
  input  logic [ADDR_W-1:0]        Write_Reg2,
  input  logic [DATA_W-1:0]        writeData2,
  input  logic [NUM_RD*ADDR_W-1:0] Read_Reg,
  output logic [NUM_RD*DATA_W-1:0] Read_Data,
  input  logic                     clear_req,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_a_en;
  logic              w_wr_b_en;

  // -------------------------------------------------------------------------
  // Clear engine
  // -------------------------------------------------------------------------
  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clock       (clock),
    .rst         (rst),
    .i_clear_req (clear_req),
    .o_busy      (w_busy),
    .o_clr_en    (w_clr_en),
    .o_clr_addr  (w_clr_addr)
  );

  assign busy = w_busy;

  // -------------------------------------------------------------------------
  // Effective write enables. Writes are dropped while clearing and to the
  // hardwired zero entry. Port B is dropped outright on an address collision
  // with an enabled port A, so the two ports never target the same entry.
  // -------------------------------------------------------------------------
  assign w_wr_a_en = RegWrite && !w_busy
                     && !(ZERO_REG && (Write_Reg == '0));

  assign w_wr_b_en = RegWrite2 && !w_busy
                     && !(ZERO_REG && (Write_Reg2 == '0))
                     && !(w_wr_a_en && (Write_Reg2 == Write_Reg));

  // -------------------------------------------------------------------------
  // Storage array
  // NOTE: the array is reset explicitly because an asynchronous reset must
  // zero every entry immediately; this makes it flops, not an SRAM macro.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_wr_a_en) begin
        r_mem[Write_Reg] <= writeData;
      end
      if (w_wr_b_en) begin
        r_mem[Write_Reg2] <= writeData2;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports (combinational), with optional same-cycle forwarding. The
  // zero-entry override comes last so entry 0 reads 0 whatever the array or
  // the write ports hold.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = Read_Reg[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
      // Write enables already exclude busy cycles and the zero entry.
      if (w_wr_a_en && (Write_Reg == w_addr)) begin
        w_data = writeData;
      end else if (w_wr_b_en && (Write_Reg2 == w_addr)) begin
        w_data = writeData2;
      end
`endif
      if (ZERO_REG && (w_addr == '0)) begin
        w_data = '0;
      end
    end

    assign Read_Data[i*DATA_W +: DATA_W] = w_data;
  end

endmodule : regfile_mp
